fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline and the read-side driver of InstructMem.
//   - Holds the PC and presents it as the byte address on the InstructMem add port.
//   - Captures the returned 32-bit word into the IF/ID pipeline register.
//   - Supports stall (hold), branch/jump redirect (squash) and wrap of the 7-bit address space.
// PARAMETERS
//   ADDR_W    7             byte-address width to InstructMem (128 B = 32 words)
//   DATA_W    32            instruction width
//   RESET_PC  7'h00         PC value loaded on reset
//   NOP_WORD  32'h00000000  word inserted into IF/ID on reset and on squash (sll $0,$0,0)
// PORTS
//   clk            in   1       rising-edge clock
//   rst            in   1       synchronous, active-high reset
//   stall          in   1       hazard-unit stall; hold PC and IF/ID
//   branch_taken   in   1       redirect request from EX/MEM
//   branch_target  in   ADDR_W  redirect byte address
//   add            out  ADDR_W  byte address to InstructMem; combinational copy of pc_q
//   instruc        in   DATA_W  word from InstructMem; combinational read of add
//   pc_out         out  ADDR_W  current PC, for debug
//   ifid_instr     out  DATA_W  IF/ID instruction
//   ifid_npc       out  ADDR_W  IF/ID PC+4 (mod 2^ADDR_W)
//   ifid_valid     out  1       IF/ID holds a real fetched instruction
// BEHAVIOUR
//   - Reset: all updates on posedge clk while rst=1.
//     pc_q=RESET_PC, ifid_instr=NOP_WORD, ifid_npc=0, ifid_valid=0.
//     add and pc_out equal RESET_PC in the cycle after the reset edge.
//   - Priority at each edge: rst > branch_taken > stall > normal advance.
//   - Normal advance:
//     ifid_instr<=instruc, ifid_npc<=pc_q+4, ifid_valid<=1, pc_q<=pc_q+4.
//   - Latency: the word at address A appears on ifid_instr one edge after add==A.
//   - Stall: pc_q, ifid_instr, ifid_npc and ifid_valid all hold. add stays constant.
//   - branch_taken: pc_q<={branch_target[ADDR_W-1:2],2'b00}.
//     IF/ID is squashed: ifid_instr=NOP_WORD, ifid_valid=0, ifid_npc=0.
//     The redirect also overrides a stall asserted in the same cycle.
//   - Alignment: PC bits [1:0] are always 0.
//     Misaligned targets are truncated to the word boundary; no trap is raised.
//   - Wrap-around: PC+4 is computed mod 2^ADDR_W. PC 7'h7C advances to 7'h00, and ifid_npc=7'h00.
//   - Reset asserted mid-stall or mid-redirect: reset values win, and any in-flight fetch is dropped.
//   - State: no FSM. The only registers are the pc_q register and the IF/ID register.
//   - No combinational path from stall or branch_taken to add.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined:
//   - Adds outputs perf_fetch[15:0] and perf_bubble[15:0].
//   - perf_fetch increments on each normal advance.
//   - perf_bubble increments on each stall cycle or squash cycle (not on reset cycles).
//   - Both counters saturate at 16'hFFFF and clear on rst.
//   FETCH_PERF_CNT_EN undefined: the ports and counters do not exist, and behaviour is otherwise identical.
// TESTING
//   1. Reset, then 4 free-run edges.
//      -> add=00,04,08,0C on successive cycles.
//      -> ifid_instr=mem[0..3] one cycle later; ifid_npc=04,08,0C,10; ifid_valid=1 from the first edge.
//   2. stall=1 for 3 cycles at PC=08.
//      -> add stays at 08; IF/ID holds mem[1] with npc=08.
//      -> on release, the next edge loads mem[2], npc=0C.
//   3. branch_taken=1, target=7'h14 at PC=0C.
//      -> next edge: add=14, ifid_valid=0, ifid_instr=NOP.
//      -> following edge: ifid_instr=mem[5], npc=18.
//   4. stall=1 and branch_taken=1 together, target=7'h23.
//      -> redirect wins; add=20 (truncated), IF/ID squashed.
//   5. Free-run from PC=7C.
//      -> ifid_instr=mem[31], ifid_npc=00, next add=00.
//   6. rst=1 mid-stall at PC=10.
//      -> add=00, ifid_valid=0.
//      -> with FETCH_PERF_CNT_EN: perf_fetch=0 and perf_bubble=0 after the reset edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage holding the PC, driving InstructMem and loading the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch and bubble counters.
module fetch_stage #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] instruc,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_npc,
  output logic              ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_fetch,
  output logic [15:0]       perf_bubble
`endif
);
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc;
  assign npc = pc_q + ADDR_W'(4);
  assign add = pc_q;
  assign pc_out = pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ifid_instr <= NOP_WORD;
      ifid_npc <= '0;
      ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      pc_q <= {branch_target[ADDR_W-1:2], 2'b00};
      ifid_instr <= NOP_WORD;
      ifid_npc <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc_q <= npc;
      ifid_instr <= instruc;
      ifid_npc <= npc;
      ifid_valid <= 1'b1;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_bubble <= '0;
    end else if (branch_taken || stall) begin
      perf_bubble <= perf_bubble + {15'd0, ~&perf_bubble};
    end else begin
      perf_fetch <= perf_fetch + {15'd0, ~&perf_fetch};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model.
module tb_fetch_stage;
  logic clk = 0, rst = 0, stall = 0, branch_taken = 0;
  logic [6:0] branch_target = '0, add, pc_out, ifid_npc;
  logic [31:0] instruc, ifid_instr;
  logic ifid_valid;
  logic [31:0] mem [32];
  int tests = 0, fails = 0;
  int m_pc, m_npc, m_valid, m_pf, m_pb;
  logic [31:0] m_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch, perf_bubble;
`endif
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .add(add), .instruc(instruc), .pc_out(pc_out),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_bubble(perf_bubble)
`endif
  );
  assign instruc = mem[add[6:2]];
  always #5 clk = ~clk;
  task automatic cycle(input logic r, input logic s, input logic b, input int t);
    int n_pc, n_npc, n_valid, n_pf, n_pb;
    logic [31:0] n_instr;
    rst = r; stall = s; branch_taken = b; branch_target = 7'(t);
    n_pc = m_pc; n_npc = m_npc; n_valid = m_valid; n_instr = m_instr; n_pf = m_pf; n_pb = m_pb;
    if (r) begin
      n_pc = 0; n_npc = 0; n_valid = 0; n_instr = 0; n_pf = 0; n_pb = 0;
    end else if (b) begin
      n_pc = (t % 128) / 4 * 4; n_npc = 0; n_valid = 0; n_instr = 0;
      n_pb = (m_pb < 65535) ? m_pb + 1 : 65535;
    end else if (s) begin
      n_pb = (m_pb < 65535) ? m_pb + 1 : 65535;
    end else begin
      n_instr = mem[m_pc / 4]; n_npc = (m_pc + 4) % 128; n_valid = 1; n_pc = n_npc;
      n_pf = (m_pf < 65535) ? m_pf + 1 : 65535;
    end
    @(posedge clk); #1;
    m_pc = n_pc; m_npc = n_npc; m_valid = n_valid; m_instr = n_instr; m_pf = n_pf; m_pb = n_pb;
    rst = 0; stall = 0; branch_taken = 0;
  endtask
  task automatic test_reset;
    cycle(1, 0, 0, 0);
    tests++; if (add !== 7'h00) begin fails++; $display("FAIL reset_add got=%h exp=00", add); end
    tests++; if (pc_out !== 7'h00) begin fails++; $display("FAIL reset_pc got=%h exp=00", pc_out); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    tests++; if (ifid_instr !== 32'h0 || ifid_npc !== 7'h0) begin fails++; $display("FAIL reset_ifid got=%h/%h exp=0/0", ifid_instr, ifid_npc); end
  endtask
  task automatic test_free_run;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      tests++; if (add !== 7'(4 * (i + 1))) begin fails++; $display("FAIL free_add[%0d] got=%h exp=%h", i, add, 7'(4 * (i + 1))); end
      tests++; if (ifid_instr !== mem[i]) begin fails++; $display("FAIL free_instr[%0d] got=%h exp=%h", i, ifid_instr, mem[i]); end
      tests++; if (ifid_npc !== 7'(4 * (i + 1)) || ifid_valid !== 1'b1) begin fails++; $display("FAIL free_npc[%0d] got=%h/%b exp=%h/1", i, ifid_npc, ifid_valid, 7'(4 * (i + 1))); end
    end
  endtask
  task automatic test_stall;
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      tests++; if (add !== 7'h08) begin fails++; $display("FAIL stall_add[%0d] got=%h exp=08", i, add); end
      tests++; if (ifid_instr !== mem[1] || ifid_npc !== 7'h08 || ifid_valid !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d] got=%h/%h exp=%h/08", i, ifid_instr, ifid_npc, mem[1]); end
    end
    cycle(0, 0, 0, 0);
    tests++; if (ifid_instr !== mem[2] || ifid_npc !== 7'h0C || add !== 7'h0C) begin fails++; $display("FAIL stall_release got=%h/%h/%h exp=%h/0C/0C", ifid_instr, ifid_npc, add, mem[2]); end
  endtask
  task automatic test_branch;
    cycle(0, 0, 1, 'h14);
    tests++; if (add !== 7'h14 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin fails++; $display("FAIL branch_squash got=%h/%b/%h exp=14/0/0", add, ifid_valid, ifid_instr); end
    cycle(0, 0, 0, 0);
    tests++; if (ifid_instr !== mem[5] || ifid_npc !== 7'h18 || ifid_valid !== 1'b1) begin fails++; $display("FAIL branch_fetch got=%h/%h exp=%h/18", ifid_instr, ifid_npc, mem[5]); end
  endtask
  task automatic test_stall_branch;
    cycle(0, 1, 1, 'h23);
    tests++; if (add !== 7'h20) begin fails++; $display("FAIL sb_add got=%h exp=20", add); end
    tests++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_npc !== 7'h0) begin fails++; $display("FAIL sb_squash got=%b/%h/%h exp=0/0/0", ifid_valid, ifid_instr, ifid_npc); end
  endtask
  task automatic test_wrap;
    cycle(0, 0, 1, 'h7C);
    cycle(0, 0, 0, 0);
    tests++; if (ifid_instr !== mem[31] || ifid_npc !== 7'h00 || add !== 7'h00) begin fails++; $display("FAIL wrap got=%h/%h/%h exp=%h/00/00", ifid_instr, ifid_npc, add, mem[31]); end
  endtask
  task automatic test_reset_mid_stall;
    cycle(0, 0, 1, 'h10); cycle(0, 0, 0, 0); cycle(0, 0, 1, 'h10); cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    tests++; if (add !== 7'h00 || ifid_valid !== 1'b0) begin fails++; $display("FAIL rst_stall got=%h/%b exp=00/0", add, ifid_valid); end
`ifdef FETCH_PERF_CNT_EN
    tests++; if (perf_fetch !== 16'h0 || perf_bubble !== 16'h0) begin fails++; $display("FAIL rst_perf got=%h/%h exp=0/0", perf_fetch, perf_bubble); end
`endif
    cycle(0, 0, 1, 'h40); cycle(0, 1, 1, 'h10); cycle(1, 0, 1, 'h40);
    tests++; if (add !== 7'h00 || ifid_valid !== 1'b0) begin fails++; $display("FAIL rst_branch got=%h/%b exp=00/0", add, ifid_valid); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 127)));
      tests++; if (add !== 7'(m_pc) || pc_out !== 7'(m_pc)) begin fails++; $display("FAIL rand_pc[%0d] got=%h exp=%h", i, add, 7'(m_pc)); end
      tests++; if (ifid_instr !== m_instr || ifid_npc !== 7'(m_npc) || ifid_valid !== m_valid[0]) begin fails++; $display("FAIL rand_ifid[%0d] got=%h/%h/%b exp=%h/%h/%b", i, ifid_instr, ifid_npc, ifid_valid, m_instr, 7'(m_npc), m_valid[0]); end
`ifdef FETCH_PERF_CNT_EN
      tests++; if (perf_fetch !== 16'(m_pf) || perf_bubble !== 16'(m_pb)) begin fails++; $display("FAIL rand_perf[%0d] got=%h/%h exp=%h/%h", i, perf_fetch, perf_bubble, 16'(m_pf), 16'(m_pb)); end
`endif
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    m_pc = 0; m_npc = 0; m_valid = 0; m_instr = 0; m_pf = 0; m_pb = 0;
    #1;
    test_reset;
    test_free_run;
    test_stall;
    test_branch;
    test_stall_branch;
    test_wrap;
    test_reset_mid_stall;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
